// File: rtl/ifft_8_seq.sv
// ifft_8_seq: 8-point radix-2 DIT inverse FFT on one time-shared butterfly, output scaled by 1/8.
// Build option: define IFFT_SAT_EN to saturate butterfly results instead of wrapping them.
module ifft_8_seq #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int PW = DATA_W + 16;  // sample x Q2.13 twiddle product
    localparam int TW = DATA_W + 2;   // rotated operand t
    localparam int SW = DATA_W + 3;   // a +/- t before halving

`ifdef IFFT_SAT_EN
    localparam logic signed [SW-2:0] SAT_HI = (SW-1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SW-2:0] SAT_LO = ~SAT_HI;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              in_fire, out_fire;

    logic [DATA_W-1:0] ent_re [8];
    logic [DATA_W-1:0] ent_im [8];

    logic [1:0]        stage, bfly, tw_e;
    logic [2:0]        i0, i1;
    logic signed [15:0]       w_re, w_im;
    logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]       d_re, d_im;
    logic signed [TW-1:0]     t_re, t_im;
    logic signed [SW-1:0]     s0_re, s0_im, s1_re, s1_im;
    logic signed [SW-2:0]     h0_re, h0_im, h1_re, h1_im;
    logic [DATA_W-1:0]        y0_re, y0_im, y1_re, y1_im;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Narrow a halved butterfly sum back to the sample width.
    function automatic logic [DATA_W-1:0] narrow(input logic signed [SW-2:0] v);
`ifdef IFFT_SAT_EN
        if (v > SAT_HI)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_LO)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return DATA_W'(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q == CALC) || (state_q == OUT);
    assign out_last  = out_valid && (cnt_q[2:0] == 3'd7);
    assign out_real  = out_valid ? ent_re[cnt_q[2:0]] : '0;
    assign out_imag  = out_valid ? ent_im[cnt_q[2:0]] : '0;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // In CALC the counter walks stage*4 + butterfly, 0..11.
    assign stage = cnt_q[3:2];
    assign bfly  = cnt_q[1:0];

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first or a full case with default), otherwise a latch is inferred.
    always_comb begin
        case (stage)
            2'd1: begin
                i0   = {bfly[1], 1'b0, bfly[0]};
                i1   = {bfly[1], 1'b1, bfly[0]};
                tw_e = {bfly[0], 1'b0};
            end
            2'd2: begin
                i0   = {1'b0, bfly};
                i1   = {1'b1, bfly};
                tw_e = bfly;
            end
            default: begin
                i0   = {bfly, 1'b0};
                i1   = {bfly, 1'b1};
                tw_e = 2'd0;
            end
        endcase
    end

    // W^e = exp(+j*2*pi*e/8) in Q2.13.
    always_comb begin
        case (tw_e)
            2'd1:    begin w_re = 16'sh16a0; w_im = 16'sh16a0; end
            2'd2:    begin w_re = 16'sh0000; w_im = 16'sh2000; end
            2'd3:    begin w_re = 16'she960; w_im = 16'sh16a0; end
            default: begin w_re = 16'sh2000; w_im = 16'sh0000; end
        endcase
    end

    always_comb begin
        a_re = ent_re[i0];
        a_im = ent_im[i0];
        b_re = ent_re[i1];
        b_im = ent_im[i1];

        p_rr = PW'(b_re) * PW'(w_re);
        p_ii = PW'(b_im) * PW'(w_im);
        p_ri = PW'(b_re) * PW'(w_im);
        p_ir = PW'(b_im) * PW'(w_re);

        d_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
        d_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);
        t_re = TW'(d_re >>> TW_FRAC);
        t_im = TW'(d_im >>> TW_FRAC);

        s0_re = SW'(a_re) + SW'(t_re);
        s0_im = SW'(a_im) + SW'(t_im);
        s1_re = SW'(a_re) - SW'(t_re);
        s1_im = SW'(a_im) - SW'(t_im);

        // Arithmetic shift floors, giving the 1/2 per stage and 1/8 overall.
        h0_re = (SW-1)'(s0_re >>> 1);
        h0_im = (SW-1)'(s0_im >>> 1);
        h1_re = (SW-1)'(s1_re >>> 1);
        h1_im = (SW-1)'(s1_im >>> 1);

        y0_re = narrow(h0_re);
        y0_im = narrow(h0_im);
        y1_re = narrow(h1_re);
        y1_im = narrow(h1_im);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && (cnt_q[2:0] == 3'd7)) state_d = CALC;
            CALC:    if (cnt_q == 4'd11) state_d = OUT;
            OUT:     if (out_fire && (cnt_q[2:0] == 3'd7)) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (state_d != state_q)
            cnt_q <= '0;
        else if (in_fire || out_fire || (state_q == CALC))
            cnt_q <= cnt_q + 4'd1;
    end

    // NOTE: the register file is only 8 complex entries in flops, so it is cleared
    // by reset; a frame aborted by reset leaves no stale data behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                ent_re[i] <= '0;
                ent_im[i] <= '0;
            end
        end else if (in_fire) begin
            ent_re[bitrev3(cnt_q[2:0])] <= in_real;
            ent_im[bitrev3(cnt_q[2:0])] <= in_imag;
        end else if (state_q == CALC) begin
            ent_re[i0] <= y0_re;
            ent_im[i0] <= y0_im;
            ent_re[i1] <= y1_re;
            ent_im[i1] <= y1_im;
        end
    end

endmodule
